// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: data width, funct3 encodings
// and FSM state encodings.
package riscv_lsu_pkg;

    localparam int unsigned XLEN = 32;

    // Memory-op funct3 encodings (loads use all five, stores use B/H/W)
    localparam logic [2:0] LSU_F3_B  = 3'd0;
    localparam logic [2:0] LSU_F3_H  = 3'd1;
    localparam logic [2:0] LSU_F3_W  = 3'd2;
    localparam logic [2:0] LSU_F3_BU = 3'd4;
    localparam logic [2:0] LSU_F3_HU = 3'd5;

    // LSU FSM state encodings
    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_WAIT = 2'd1;
    localparam logic [1:0] LSU_ST_RESP = 2'd2;

    // Data memory is word addressed; byte offset is carried separately
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic for the LSU: legality/alignment check, store byte
// enables and lane-replicated store data, and load byte/half extract with extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [1:0]      req_off_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            req_excp_o,
    output logic [3:0]      req_be_o,
    output logic [XLEN-1:0] req_lane_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_word_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shifted;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    // Request side: flag illegal/misaligned ops and build store lanes
    always_comb begin
        req_excp_o       = 1'b0;
        req_be_o         = 4'hF;
        req_lane_wdata_o = req_wdata_i;
        if (req_we_i) begin
            case (req_funct3_i)
                LSU_F3_B: begin
                    req_be_o         = 4'b0001 << req_off_i;
                    req_lane_wdata_o = {4{req_wdata_i[7:0]}};
                end
                LSU_F3_H: begin
                    req_be_o         = 4'b0011 << req_off_i;
                    req_lane_wdata_o = {2{req_wdata_i[15:0]}};
                    req_excp_o       = req_off_i[0];
                end
                LSU_F3_W: req_excp_o = |req_off_i;
                default:  req_excp_o = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                LSU_F3_B, LSU_F3_BU: req_excp_o = 1'b0;
                LSU_F3_H, LSU_F3_HU: req_excp_o = req_off_i[0];
                LSU_F3_W:            req_excp_o = |req_off_i;
                default:             req_excp_o = 1'b1;
            endcase
        end
    end

    // Load side: move the addressed byte/half down to bit 0, then extend
    always_comb begin
        ld_shifted = ld_word_i >> {ld_off_i, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = ld_shifted[15:0];
        case (ld_funct3_i)
            LSU_F3_B:  ld_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LSU_F3_BU: ld_data_o = {{(XLEN-8){1'b0}}, ld_byte};
            LSU_F3_H:  ld_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
            LSU_F3_HU: ld_data_o = {{(XLEN-16){1'b0}}, ld_half};
            default:   ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit. Accepts one op per req/ready handshake, runs a req/ack
// data-memory transaction and returns extended load data with a one-cycle done.
// Optional feature: define RISCV_LSU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without ack (reported through o_lsu_fault).
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_lsu_req,
    output logic            o_lsu_ready,
    input  logic            i_lsu_we,
    input  logic [2:0]      i_lsu_funct3,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic            o_lsu_done,
    output logic            o_lsu_excp,
    output logic            o_lsu_fault,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    logic [1:0]      state_q;
    logic            dmem_req_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_wdata_q;
    logic [3:0]      dmem_be_q;
    logic [2:0]      ld_funct3_q;
    logic [1:0]      ld_off_q;
    logic [XLEN-1:0] rdata_q;
    logic            done_q;
    logic            excp_q;

    logic            req_excp;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_lane_wdata;
    logic [XLEN-1:0] ld_data;

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] cnt_q;
    logic            fault_q;
    assign o_lsu_fault = fault_q;
`else
    assign o_lsu_fault = 1'b0;
`endif

    riscv_lsu_align u_align (
        .req_we_i         (i_lsu_we),
        .req_funct3_i     (i_lsu_funct3),
        .req_off_i        (i_lsu_addr[1:0]),
        .req_wdata_i      (i_lsu_wdata),
        .req_excp_o       (req_excp),
        .req_be_o         (req_be),
        .req_lane_wdata_o (req_lane_wdata),
        .ld_funct3_i      (ld_funct3_q),
        .ld_off_i         (ld_off_q),
        .ld_word_i        (i_dmem_rdata),
        .ld_data_o        (ld_data)
    );

    // FSM, memory-port registers and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= LSU_ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= 4'h0;
            ld_funct3_q  <= 3'd0;
            ld_off_q     <= 2'd0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            excp_q       <= 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
            cnt_q        <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses
            done_q <= 1'b0;
            excp_q <= 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                LSU_ST_IDLE: begin
                    if (i_lsu_req) begin
                        if (req_excp) begin
                            // Rejected op never touches memory
                            state_q <= LSU_ST_RESP;
                            done_q  <= 1'b1;
                            excp_q  <= 1'b1;
                        end else begin
                            state_q      <= LSU_ST_WAIT;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= i_lsu_we;
                            dmem_addr_q  <= word_addr(i_lsu_addr);
                            dmem_wdata_q <= req_lane_wdata;
                            dmem_be_q    <= i_lsu_we ? req_be : 4'hF;
                            ld_funct3_q  <= i_lsu_funct3;
                            ld_off_q     <= i_lsu_addr[1:0];
`ifdef RISCV_LSU_TIMEOUT_EN
                            cnt_q        <= '0;
`endif
                        end
                    end
                end
                LSU_ST_WAIT: begin
                    if (i_dmem_ack) begin
                        state_q    <= LSU_ST_RESP;
                        dmem_req_q <= 1'b0;
                        done_q     <= 1'b1;
                        if (!dmem_we_q) begin
                            rdata_q <= ld_data;
                        end
                    end
`ifdef RISCV_LSU_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= LSU_ST_RESP;
                        dmem_req_q <= 1'b0;
                        done_q     <= 1'b1;
                        fault_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
                LSU_ST_RESP: state_q <= LSU_ST_IDLE;
                default:     state_q <= LSU_ST_IDLE;
            endcase
        end
    end

    assign o_lsu_ready  = (state_q == LSU_ST_IDLE);
    assign o_lsu_rdata  = rdata_q;
    assign o_lsu_done   = done_q;
    assign o_lsu_excp   = excp_q;
    assign o_dmem_req   = dmem_req_q;
    assign o_dmem_we    = dmem_we_q;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_dmem_be    = dmem_be_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: expected results are queued when an op is
// issued and popped when the LSU reports done. Timeout scenario runs only when
// RISCV_LSU_TIMEOUT_EN is defined.
module tb_riscv_lsu;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_excp;
    logic        lsu_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_lsu_req    (lsu_req),
        .o_lsu_ready  (lsu_ready),
        .i_lsu_we     (lsu_we),
        .i_lsu_funct3 (lsu_funct3),
        .i_lsu_addr   (lsu_addr),
        .i_lsu_wdata  (lsu_wdata),
        .o_lsu_rdata  (lsu_rdata),
        .o_lsu_done   (lsu_done),
        .o_lsu_excp   (lsu_excp),
        .o_lsu_fault  (lsu_fault),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_be    (dmem_be),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata)
    );

    typedef struct {
        logic        saw_req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        excp;
        logic        fault;
        int          edges;
    } exp_t;

    typedef struct {
        logic        saw_req;
        logic        stable;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        excp;
        logic        fault;
        int          done_cnt;
        int          edges;
        logic        ready_after;
    } obs_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rdata;

    // Reference load extraction written per byte lane
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Issue one op, act as memory (ack after ack_lat req cycles; <0 = never), observe result
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int ack_lat,
                          output obs_t o);
        int k;
        int req_n;
        o.saw_req = 1'b0; o.stable = 1'b1; o.we = 1'b0; o.addr = '0; o.wdata = '0;
        o.be = '0; o.rdata = '0; o.excp = 1'b0; o.fault = 1'b0; o.done_cnt = 0;
        o.edges = -1; o.ready_after = 1'b0;
        k = 0;
        while (!lsu_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        req_n = 0;
        for (int c = 0; c < 64; c++) begin
            if (lsu_done) begin
                o.done_cnt++; o.edges = c; o.rdata = lsu_rdata;
                o.excp = lsu_excp; o.fault = lsu_fault;
                break;
            end
            if (dmem_req) begin
                if (!o.saw_req) begin
                    o.saw_req = 1'b1; o.we = dmem_we; o.addr = dmem_addr;
                    o.wdata = dmem_wdata; o.be = dmem_be;
                end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} !==
                             {o.we, o.addr, o.wdata, o.be}) begin
                    o.stable = 1'b0;
                end
                dmem_ack   = (ack_lat >= 0) && (req_n == ack_lat);
                dmem_rdata = word;
                req_n++;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        @(posedge clk); #1;
        if (lsu_done) o.done_cnt++;
        o.ready_after = lsu_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({lsu_ready, lsu_done, lsu_excp, lsu_fault, lsu_rdata} !== {1'b1, 3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_lsu got ready=%0b done=%0b excp=%0b fault=%0b rdata=%h want 1 0 0 0 0",
                     lsu_ready, lsu_done, lsu_excp, lsu_fault, lsu_rdata);
        end
        n_tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_dmem got req=%0b we=%0b addr=%h wdata=%h be=%h want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
        end
        rst = 1'b0;
        model_rdata = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        obs_t o;
        exp_t e;
        exp_q.push_back('{saw_req: 1'b1, we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF,
                          be: 4'hF, rdata: model_rdata, excp: 1'b0, fault: 1'b0, edges: 3});
        run_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, o);
        e = exp_q.pop_front();
        n_tests++;
        if ({o.saw_req, o.stable, o.we, o.addr, o.wdata, o.be} !==
            {e.saw_req, 1'b1, e.we, e.addr, e.wdata, e.be}) begin
            n_fail++;
            $display("FAIL sw_port got req=%0b stable=%0b we=%0b addr=%h wdata=%h be=%h want 1 1 1 %h %h %h",
                     o.saw_req, o.stable, o.we, o.addr, o.wdata, o.be, e.addr, e.wdata, e.be);
        end
        n_tests++;
        if (o.done_cnt !== 1 || o.edges !== e.edges || o.excp !== e.excp || o.fault !== e.fault ||
            o.rdata !== e.rdata || o.ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_done got dones=%0d at=%0d excp=%0b fault=%0b rdata=%h ready=%0b want 1 %0d 0 0 %h 1",
                     o.done_cnt, o.edges, o.excp, o.fault, o.rdata, o.ready_after, e.edges, e.rdata);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s   [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
        logic [31:0] addrs [6] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200, 32'h201};
        logic [31:0] word;
        obs_t o;
        exp_t e;
        word = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            model_rdata = model_load(f3s[i], addrs[i][1:0], word);
            exp_q.push_back('{saw_req: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF,
                              rdata: model_rdata, excp: 1'b0, fault: 1'b0, edges: i % 3 + 1});
            run_op(1'b0, f3s[i], addrs[i], 32'h0, word, i % 3, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o.rdata !== e.rdata || o.done_cnt !== 1 || o.edges !== e.edges || o.excp !== 1'b0) begin
                n_fail++;
                $display("FAIL load_%0d got rdata=%h dones=%0d at=%0d excp=%0b want %h 1 %0d 0",
                         i, o.rdata, o.done_cnt, o.edges, o.excp, e.rdata, e.edges);
            end
            n_tests++;
            if ({o.saw_req, o.we, o.addr, o.be} !== {e.saw_req, e.we, e.addr, e.be}) begin
                n_fail++;
                $display("FAIL load_port_%0d got req=%0b we=%0b addr=%h be=%h want 1 0 %h f",
                         i, o.saw_req, o.we, o.addr, o.be, e.addr);
            end
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3s   [3] = '{3'd1, 3'd0, 3'd1};
        logic [31:0] addrs [3] = '{32'h6, 32'h5, 32'h10};
        logic [31:0] wd    [3] = '{32'h1234ABCD, 32'h000000EF, 32'h55667788};
        logic [31:0] xw    [3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h77887788};
        logic [3:0]  xbe   [3] = '{4'b1100, 4'b0010, 4'b0011};
        logic [31:0] xa    [3] = '{32'h4, 32'h4, 32'h10};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{saw_req: 1'b1, we: 1'b1, addr: xa[i], wdata: xw[i], be: xbe[i],
                              rdata: model_rdata, excp: 1'b0, fault: 1'b0, edges: 1});
            run_op(1'b1, f3s[i], addrs[i], wd[i], 32'h0, 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if ({o.addr, o.wdata, o.be, o.we} !== {e.addr, e.wdata, e.be, e.we} ||
                o.done_cnt !== 1 || o.rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL store_lane_%0d got addr=%h wdata=%h be=%b we=%0b dones=%0d rdata=%h want %h %h %b 1 1 %h",
                         i, o.addr, o.wdata, o.be, o.we, o.done_cnt, o.rdata, e.addr, e.wdata,
                         e.be, e.rdata);
            end
        end
    endtask

    task automatic test_exceptions();
        logic        wes   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s   [5] = '{3'd2, 3'd5, 3'd1, 3'd3, 3'd4};
        logic [31:0] addrs [5] = '{32'h102, 32'h1, 32'h3, 32'h0, 32'h0};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{saw_req: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0,
                              rdata: model_rdata, excp: 1'b1, fault: 1'b0, edges: 0});
            run_op(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, 32'h11111111, 0, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o.saw_req !== e.saw_req || o.excp !== e.excp || o.edges !== e.edges ||
                o.done_cnt !== 1 || o.rdata !== e.rdata || o.ready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL excp_%0d got req=%0b excp=%0b at=%0d dones=%0d rdata=%h ready=%0b want 0 1 0 1 %h 1",
                         i, o.saw_req, o.excp, o.edges, o.done_cnt, o.rdata, o.ready_after, e.rdata);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int   k;
        logic stray;
        obs_t o;
        exp_t e;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'd2; lsu_addr = 32'h40; lsu_wdata = 32'h55;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        k = 0;
        while (!dmem_req && k < 10) begin
            @(posedge clk); #1; k++;
        end
        n_tests++;
        if (dmem_req !== 1'b1 || lsu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_wait got req=%0b ready=%0b want 1 0", dmem_req, lsu_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 32'h0;
        n_tests++;
        if ({dmem_req, lsu_ready, lsu_done, lsu_rdata} !== {3'b010, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_after got req=%0b ready=%0b done=%0b rdata=%h want 0 1 0 0",
                     dmem_req, lsu_ready, lsu_done, lsu_rdata);
        end
        // Stray acks while idle must not produce anything
        stray = 1'b0;
        dmem_ack = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (lsu_done || dmem_req || !lsu_ready) stray = 1'b1;
        end
        dmem_ack = 1'b0;
        n_tests++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack got activity=%0b want 0", stray);
        end
        model_rdata = model_load(3'd2, 2'd0, 32'h13572468);
        exp_q.push_back('{saw_req: 1'b1, we: 1'b0, addr: 32'h80, wdata: 32'h0, be: 4'hF,
                          rdata: model_rdata, excp: 1'b0, fault: 1'b0, edges: 2});
        run_op(1'b0, 3'd2, 32'h80, 32'h0, 32'h13572468, 1, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o.rdata !== e.rdata || o.done_cnt !== 1 || o.edges !== e.edges || o.addr !== e.addr) begin
            n_fail++;
            $display("FAIL rst_then_op got rdata=%h dones=%0d at=%0d addr=%h want %h 1 %0d %h",
                     o.rdata, o.done_cnt, o.edges, o.addr, e.rdata, e.edges, e.addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] base, word, data;
        logic        we;
        int          lat;
        obs_t        o;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            we   = (i % 3 == 2);
            f3   = we ? 3'd2 : ld_f3s[$urandom_range(0, 4)];
            off  = 2'($urandom_range(0, 3));
            if (f3 == 3'd1 || f3 == 3'd5) off[0] = 1'b0;
            if (f3 == 3'd2) off = 2'd0;
            base = $urandom & 32'hFFFF_FFFC;
            word = $urandom;
            data = $urandom;
            lat  = $urandom_range(0, 3);
            if (!we) model_rdata = model_load(f3, off, word);
            exp_q.push_back('{saw_req: 1'b1, we: we, addr: base, wdata: we ? data : 32'h0,
                              be: 4'hF, rdata: model_rdata, excp: 1'b0, fault: 1'b0,
                              edges: lat + 1});
            run_op(we, f3, base | {30'h0, off}, data, word, lat, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o.rdata !== e.rdata || o.addr !== e.addr || o.we !== e.we || o.be !== e.be ||
                (e.we && o.wdata !== e.wdata) || o.done_cnt !== 1 || o.edges !== e.edges ||
                o.stable !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d got rdata=%h addr=%h we=%0b be=%h wdata=%h dones=%0d at=%0d stable=%0b want %h %h %0b %h %h 1 %0d 1",
                         i, o.rdata, o.addr, o.we, o.be, o.wdata, o.done_cnt, o.edges, o.stable,
                         e.rdata, e.addr, e.we, e.be, e.wdata, e.edges);
            end
        end
    endtask

`ifdef RISCV_LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        exp_q.push_back('{saw_req: 1'b1, we: 1'b1, addr: 32'h300, wdata: 32'h0BADF00D, be: 4'hF,
                          rdata: model_rdata, excp: 1'b0, fault: 1'b1, edges: TB_TIMEOUT});
        run_op(1'b1, 3'd2, 32'h300, 32'h0BADF00D, 32'h0, -1, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o.fault !== e.fault || o.excp !== e.excp || o.edges !== e.edges ||
            o.done_cnt !== 1 || o.rdata !== e.rdata || o.ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout got fault=%0b excp=%0b at=%0d dones=%0d rdata=%h ready=%0b want 1 0 %0d 1 %h 1",
                     o.fault, o.excp, o.edges, o.done_cnt, o.rdata, o.ready_after, e.edges, e.rdata);
        end
        // Ack on the terminal WAIT cycle completes normally
        model_rdata = 32'h24681357;
        exp_q.push_back('{saw_req: 1'b1, we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'hF,
                          rdata: model_rdata, excp: 1'b0, fault: 1'b0, edges: TB_TIMEOUT});
        run_op(1'b0, 3'd2, 32'h300, 32'h0, 32'h24681357, TB_TIMEOUT - 1, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o.fault !== e.fault || o.edges !== e.edges || o.done_cnt !== 1 || o.rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL timeout_ack_wins got fault=%0b at=%0d dones=%0d rdata=%h want 0 %0d 1 %h",
                     o.fault, o.edges, o.done_cnt, o.rdata, e.edges, e.rdata);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = '0;
        lsu_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        model_rdata = '0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_store_lanes();
        test_exceptions();
        test_reset_mid_op();
        test_back_to_back();
`ifdef RISCV_LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
